// File: rtl/m_seq_pkg.sv
// Shared constants and state encoding for the m-sequence generator and checker.
package m_seq_pkg;

    localparam int unsigned SEQ_ORDER        = 10;
    localparam int unsigned SEQ_TAP          = 7;
    localparam int unsigned SEQ_PERIOD       = 1023;
    localparam int unsigned LOCK_MATCHES_DEF = 16;
    localparam int unsigned LOSS_ERRS_DEF    = 4;
    localparam int unsigned CNT_W_DEF        = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_HUNT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

endpackage

// File: rtl/m_seq_chk_if.sv
// Serial bit stream in, lock/error status out.
interface m_seq_chk_if
    import m_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             en;
    logic             data_in;
    logic             clr;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             seq_done;

    modport master (
        output en, data_in, clr,
        input  locked, err, err_cnt, seq_done
    );

    modport slave (
        input  en, data_in, clr,
        output locked, err, err_cnt, seq_done
    );
endinterface

// File: rtl/m_seq_pred.sv
// History shift register and next-bit predictor for x^10 + x^7 + 1.
module m_seq_pred
    import m_seq_pkg::*;
#(
    parameter int unsigned ORDER = SEQ_ORDER
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_i,
    input  logic free_run_i,
    input  logic data_i,
    output logic pred_o,
    output logic next_nz_o
);

    logic [ORDER-1:0] hist_q;
    logic [ORDER-1:0] hist_d;
    logic             in_c;

    // Predicted bit taken from the two recurrence taps (hist[0] is newest)
    always_comb begin
        pred_o = hist_q[ORDER-1] ^ hist_q[SEQ_TAP-1];
    end

    // Pick received or predicted bit and form the shifted history
    always_comb begin
        in_c      = free_run_i ? pred_o : data_i;
        hist_d    = shift_i ? {hist_q[ORDER-2:0], in_c} : hist_q;
        next_nz_o = |hist_d;
    end

    // History register
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/m_seq_chk.sv
// PRBS m-sequence checker: fills, hunts for lock, then counts bit errors.
module m_seq_chk
    import m_seq_pkg::*;
#(
    parameter int unsigned ORDER        = SEQ_ORDER,
    parameter int unsigned LOCK_MATCHES = LOCK_MATCHES_DEF,
    parameter int unsigned LOSS_ERRS    = LOSS_ERRS_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    m_seq_chk_if.slave bus
);

    localparam int unsigned PER_W   = $clog2(SEQ_PERIOD);
    localparam int unsigned FILL_W  = $clog2(ORDER + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int unsigned LOSS_W  = $clog2(LOSS_ERRS + 1);

    state_e             state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic pred_c, next_nz_c, mismatch_c;
    logic fill_done_c, lock_hit_c, loss_hit_c;

    m_seq_pred #(
        .ORDER (ORDER)
    ) u_pred (
        .clk        (clk),
        .rst        (rst),
        .shift_i    (bus.en),
        .free_run_i (state_q == ST_LOCKED),
        .data_i     (bus.data_in),
        .pred_o     (pred_c),
        .next_nz_o  (next_nz_c)
    );

    // Transition conditions; an all-zero history is never accepted as lock
    always_comb begin
        mismatch_c  = bus.data_in ^ pred_c;
        fill_done_c = (fill_q == FILL_W'(ORDER - 1));
        lock_hit_c  = !mismatch_c && (match_q >= MATCH_W'(LOCK_MATCHES - 1)) && next_nz_c;
        loss_hit_c  = mismatch_c && (loss_q == LOSS_W'(LOSS_ERRS - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; only en=1 cycles advance
    always_comb begin
        state_d = state_q;
        if (bus.en) begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_FILL;
                ST_FILL:   if (fill_done_c) state_d = ST_HUNT;
                ST_HUNT:   if (lock_hit_c)  state_d = ST_LOCKED;
                ST_LOCKED: if (loss_hit_c)  state_d = ST_FILL;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Counter and output next values
    always_comb begin
        fill_d    = fill_q;
        match_d   = match_q;
        loss_d    = loss_q;
        per_d     = per_q;
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
        done_d    = 1'b0;
        locked_d  = (state_d == ST_LOCKED);
        if (bus.en) begin
            unique case (state_q)
                ST_IDLE: begin
                    fill_d  = FILL_W'(1);
                    match_d = '0;
                end
                ST_FILL: begin
                    fill_d  = fill_done_c ? '0 : fill_q + FILL_W'(1);
                    match_d = '0;
                end
                ST_HUNT: begin
                    if (mismatch_c) begin
                        match_d = '0;
                    end else if (match_q < MATCH_W'(LOCK_MATCHES)) begin
                        match_d = match_q + MATCH_W'(1);
                    end
                    if (lock_hit_c) begin
                        match_d = '0;
                        loss_d  = '0;
                        per_d   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (mismatch_c) begin
                        err_d  = 1'b1;
                        loss_d = loss_q + LOSS_W'(1);
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (loss_hit_c) begin
                            loss_d  = '0;
                            fill_d  = '0;
                            match_d = '0;
                        end
                    end else begin
                        loss_d = '0;
                    end
                    if (per_q == PER_W'(SEQ_PERIOD - 1)) begin
                        per_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        per_d = per_q + PER_W'(1);
                    end
                end
                default: ;
            endcase
        end
        if (bus.clr) begin
            err_cnt_d = '0;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_q    <= '0;
            match_q   <= '0;
            loss_q    <= '0;
            per_q     <= '0;
            err_cnt_q <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            fill_q    <= fill_d;
            match_q   <= match_d;
            loss_q    <= loss_d;
            per_q     <= per_d;
            err_cnt_q <= err_cnt_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign bus.locked   = locked_q;
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.seq_done = done_q;

endmodule
